gen_display_ctrl: RTL and testbench

GEN_DISPLAY_CTRL -- requirements
Module: gen_display_ctrl

---
 rtl/gol_disp_pkg.sv | 22 ++
 rtl/bcd_counter4.sv | 49 ++++
 rtl/gen_display_ctrl.sv | 126 ++++++++++++
 tb/tb_gen_display_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_disp_pkg.sv
// Shared types and constants for the generation controller and its
// four-digit iteration display.
package gol_disp_pkg;

    // Generation sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Digit code that the display decoder renders as an unlit digit.
    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam int         NUM_DIGITS = 4;

    // Active-low anode pattern for a scanned digit; the upper four anodes stay off.
    function automatic logic [7:0] anode_for(input logic [1:0] sel);
        anode_for = ~(8'd1 << sel);
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter with synchronous clear and 9999 -> 0000 wrap.
// Clear has priority over increment so that a simultaneous pair reads 0000.
module bcd_counter4
    import gol_disp_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        inc_i,
    input  logic        clr_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;
    logic        carry;

    // Next count: ripple a carry upward, each digit rolling over only at 9.
    always_comb begin
        count_d = count_q;
        carry   = 1'b0;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            carry = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (carry) begin
                    if (count_q[i*4 +: 4] == 4'd9) begin
                        count_d[i*4 +: 4] = 4'd0;
                    end else begin
                        count_d[i*4 +: 4] = count_q[i*4 +: 4] + 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/gen_display_ctrl.sv
// Generation controller for a life engine plus a multiplexed four-digit
// display of the iteration count.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the digits above the
// most significant nonzero digit (digit 0 always shows).
// The sequencing state is held in state_q (type state_t) for observation.
// Handshake: gen_start is a one-cycle request to the engine; the engine
// answers with a one-cycle gen_done while busy is high. A gen_done seen in
// any other state is dropped, and step_req only counts in ST_IDLE.
module gen_display_ctrl
    import gol_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GEN_DIV     = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_en,
    input  logic        step_req,
    input  logic        clear,
    input  logic        gen_done,
    output logic        gen_start,
    output logic        busy,
    output logic [15:0] iter_bcd,
    output logic [1:0]  digit_sel,
    output logic [3:0]  digit_bcd,
    output logic [7:0]  anode
);

    localparam int PACE_W = (GEN_DIV > 1) ? $clog2(GEN_DIV) : 1;
    localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(GEN_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);

    state_t            state_q, state_d;
    logic [PACE_W-1:0] pace_q, pace_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [1:0]        sel_q, sel_d;
    logic [7:0]        anode_q, anode_d;
    logic [3:0]        dbcd_q, dbcd_d;
    logic              count_inc;
`ifdef LEADING_ZERO_BLANK_EN
    logic [1:0]        msd;
`endif

    bcd_counter4 u_count (
        .clk_i   (clk),
        .reset_i (reset),
        .inc_i   (count_inc),
        .clr_i   (clear),
        .count_o (iter_bcd)
    );

    // Generation sequencing: next state, pacing count and strobes.
    always_comb begin
        state_d   = state_q;
        pace_d    = '0;
        gen_start = 1'b0;
        busy      = 1'b0;
        count_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (step_req || run_en) state_d = ST_START;
            end
            ST_START: begin
                gen_start = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (gen_done) begin
                    count_inc = 1'b1;
                    state_d   = run_en ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!run_en) begin
                    state_d = ST_IDLE;
                end else if (pace_q == PACE_LAST) begin
                    state_d = ST_START;
                end else begin
                    pace_d = pace_q + PACE_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan: prescaler wrap advances the digit; anode and value follow the new digit.
    always_comb begin
        scan_d  = (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_W'(1);
        sel_d   = (scan_q == SCAN_LAST) ? sel_q + 2'd1 : sel_q;
        anode_d = anode_for(sel_d);
        dbcd_d  = iter_bcd[{sel_d, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        msd = 2'd0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (iter_bcd[i*4 +: 4] != 4'd0) msd = 2'(i);
        end
        if (sel_d > msd) dbcd_d = BLANK_CODE;
`endif
    end

    // State, pacing and scan registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pace_q  <= '0;
            scan_q  <= '0;
            sel_q   <= 2'd0;
            anode_q <= 8'hFE;
            dbcd_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            pace_q  <= pace_d;
            scan_q  <= scan_d;
            sel_q   <= sel_d;
            anode_q <= anode_d;
            dbcd_q  <= dbcd_d;
        end
    end

    assign digit_sel = sel_q;
    assign anode     = anode_q;
    assign digit_bcd = dbcd_q;

endmodule

// File: tb/tb_gen_display_ctrl.sv
// Self-checking bench for gen_display_ctrl with short pacing and scan
// periods (GEN_DIV=10, REFRESH_DIV=4). Expected values come from a decimal
// iteration model converted to BCD and from fixed scan tables.
`timescale 1ns/1ps
module tb_gen_display_ctrl;
    import gol_disp_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run_en = 1'b0;
    logic        step_req = 1'b0;
    logic        clear = 1'b0;
    logic        gen_done = 1'b0;
    logic        gen_start;
    logic        busy;
    logic [15:0] iter_bcd;
    logic [1:0]  digit_sel;
    logic [3:0]  digit_bcd;
    logic [7:0]  anode;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int model_n  = 0;

    logic [15:0] cnt_q[$];
    logic [13:0] exp_q[$];

    gen_display_ctrl #(.REFRESH_DIV(4), .GEN_DIV(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .run_en    (run_en),
        .step_req  (step_req),
        .clear     (clear),
        .gen_done  (gen_done),
        .gen_start (gen_start),
        .busy      (busy),
        .iter_bcd  (iter_bcd),
        .digit_sel (digit_sel),
        .digit_bcd (digit_bcd),
        .anode     (anode)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gen_start(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            if (gen_start === 1'b1) seen = 1'b1;
            else tick();
        end
    endtask

    // One paused step; gen_done lands done_gap cycles after gen_start.
    task automatic do_step(input int done_gap, input bit with_clear, input string tag);
        bit seen;
        logic [15:0] e;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        wait_gen_start(4, seen);
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_start: gen_start not seen within 4 cycles", tag);
        end
        for (int i = 0; i < done_gap; i++) tick();
        gen_done = 1'b1;
        clear    = with_clear;
        model_n  = with_clear ? 0 : (model_n + 1) % 10000;
        cnt_q.push_back(to_bcd(model_n));
        tick();
        gen_done = 1'b0;
        clear    = 1'b0;
        e = cnt_q.pop_front();
        n_checks++;
        if (iter_bcd !== e) begin
            n_fail++;
            $display("FAIL %s_count: got %h expected %h", tag, iter_bcd, e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({iter_bcd, digit_sel, gen_start, busy, anode, digit_bcd} !==
            {16'h0000, 2'd0, 1'b0, 1'b0, 8'hFE, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs: iter=%h sel=%0d gs=%b busy=%b an=%h dig=%h",
                     iter_bcd, digit_sel, gen_start, busy, anode, digit_bcd);
        end
        n_checks++;
        if (dut.state_q !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE);
        end
        reset = 1'b0;
        model_n = 0;
    endtask

    task automatic test_step();
        logic [15:0] e;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        n_checks++;
        if (gen_start !== 1'b1) begin
            n_fail++;
            $display("FAIL step_latency: gen_start=%b expected 1", gen_start);
        end
        tick();
        n_checks++;
        if ({gen_start, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL step_wait: gs=%b busy=%b expected 0 1", gen_start, busy);
        end
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        repeat (2) tick();
        gen_done = 1'b1;
        model_n = 1;
        cnt_q.push_back(to_bcd(model_n));
        tick();
        gen_done = 1'b0;
        e = cnt_q.pop_front();
        n_checks++;
        if ({iter_bcd, busy} !== {e, 1'b0} || dut.state_q !== ST_IDLE) begin
            n_fail++;
            $display("FAIL step_done: iter=%h busy=%b state=%0d expected %h 0 IDLE",
                     iter_bcd, busy, dut.state_q, e);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (gen_start !== 1'b0) begin
                n_fail++;
                $display("FAIL step_not_queued: gen_start=%b at idle cycle %0d", gen_start, i);
            end
            tick();
        end
        gen_done = 1'b1;
        cnt_q.push_back(to_bcd(model_n));
        tick();
        gen_done = 1'b0;
        e = cnt_q.pop_front();
        n_checks++;
        if (iter_bcd !== e) begin
            n_fail++;
            $display("FAIL stray_done: iter=%h expected %h", iter_bcd, e);
        end
    endtask

    task automatic test_run();
        bit seen;
        int prev_t;
        logic [15:0] e;
        prev_t = -1;
        run_en = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_gen_start(40, seen);
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL run_start%0d: gen_start not seen within 40 cycles", g);
            end
            if (prev_t >= 0) begin
                n_checks++;
                if (cyc - prev_t < 10) begin
                    n_fail++;
                    $display("FAIL run_spacing%0d: got %0d cycles expected >= 10", g, cyc - prev_t);
                end
            end
            prev_t = cyc;
            if (g == 3) run_en = 1'b0;
            repeat (3) tick();
            gen_done = 1'b1;
            model_n = model_n + 1;
            cnt_q.push_back(to_bcd(model_n));
            tick();
            gen_done = 1'b0;
            e = cnt_q.pop_front();
            n_checks++;
            if (iter_bcd !== e) begin
                n_fail++;
                $display("FAIL run_count%0d: got %h expected %h", g, iter_bcd, e);
            end
        end
        n_checks++;
        if (dut.state_q !== ST_IDLE || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL run_stop_wait: state=%0d busy=%b expected IDLE 0", dut.state_q, busy);
        end
        // step_req and run_en together, then run_en dropped mid-hold.
        run_en = 1'b1;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        n_checks++;
        if ({gen_start, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL run_single_start: gs=%b busy=%b expected 0 1", gen_start, busy);
        end
        gen_done = 1'b1;
        model_n = model_n + 1;
        tick();
        gen_done = 1'b0;
        repeat (2) tick();
        run_en = 1'b0;
        tick();
        n_checks++;
        if (dut.state_q !== ST_IDLE || iter_bcd !== to_bcd(model_n)) begin
            n_fail++;
            $display("FAIL run_stop_hold: state=%0d iter=%h expected IDLE %h",
                     dut.state_q, iter_bcd, to_bcd(model_n));
        end
    endtask

    task automatic test_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_n = 0;
        n_checks++;
        if (iter_bcd !== 16'h0000 || dut.state_q !== ST_IDLE) begin
            n_fail++;
            $display("FAIL clear_alone: iter=%h state=%0d expected 0000 IDLE", iter_bcd, dut.state_q);
        end
        do_step(1, 1'b0, "clear_pre");
        do_step(2, 1'b1, "clear_with_done");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 9999; i++) do_step(1, 1'b0, "wrap_fill");
        n_checks++;
        if (iter_bcd !== 16'h9999) begin
            n_fail++;
            $display("FAIL wrap_preload: got %h expected 9999", iter_bcd);
        end
        do_step(1, 1'b0, "wrap_over");
    endtask

    task automatic test_scan();
        bit synced;
        logic [1:0] prev;
        logic [13:0] e;
        logic [3:0] hi_dig;
`ifdef LEADING_ZERO_BLANK_EN
        hi_dig = BLANK_CODE;
`else
        hi_dig = 4'h0;
`endif
        for (int i = 0; i < 42; i++) do_step(1, 1'b0, "scan_fill");
        exp_q.push_back({2'd0, 8'hFE, 4'h2});
        exp_q.push_back({2'd1, 8'hFD, 4'h4});
        exp_q.push_back({2'd2, 8'hFB, hi_dig});
        exp_q.push_back({2'd3, 8'hF7, hi_dig});
        synced = 1'b0;
        prev = digit_sel;
        for (int i = 0; i < 30 && !synced; i++) begin
            tick();
            if (digit_sel === 2'd0 && prev === 2'd3) synced = 1'b1;
            prev = digit_sel;
        end
        n_checks++;
        if (!synced) begin
            n_fail++;
            $display("FAIL scan_sync: no digit 3 -> 0 transition within 30 cycles");
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if ({digit_sel, anode, digit_bcd} !== e) begin
                    n_fail++;
                    $display("FAIL scan_digit%0d_c%0d: sel=%0d an=%h dig=%h expected sel=%0d an=%h dig=%h",
                             e[13:12], k, digit_sel, anode, digit_bcd, e[13:12], e[11:4], e[3:0]);
                end
                tick();
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        logic [15:0] e;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        wait_gen_start(4, seen);
        tick();
        n_checks++;
        if (!seen || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wait_enter: seen=%b busy=%b expected 1 1", seen, busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_n = 0;
        n_checks++;
        if ({anode, busy, iter_bcd} !== {8'hFE, 1'b0, 16'h0000} || dut.state_q !== ST_IDLE) begin
            n_fail++;
            $display("FAIL rst_wait_reset: an=%h busy=%b iter=%h state=%0d expected FE 0 0000 IDLE",
                     anode, busy, iter_bcd, dut.state_q);
        end
        gen_done = 1'b1;
        cnt_q.push_back(to_bcd(model_n));
        tick();
        gen_done = 1'b0;
        e = cnt_q.pop_front();
        n_checks++;
        if ({iter_bcd, busy, gen_start} !== {e, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_wait_late_done: iter=%h busy=%b gs=%b expected %h 0 0",
                     iter_bcd, busy, gen_start, e);
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_run();
        test_clear();
        test_wrap();
        test_scan();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
